// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between a core and a
// word-wide memory whose words are stored big-endian-in-lanes (bits [31:24]
// hold the byte at the word address, bits [7:0] the byte at address+3).
// Loads and stores are presented little-endian to the core, so word data is
// byte-swapped and sub-word stores go through a read-modify-write.
//
// Optional build macro: LSU_RANGE_CHECK_EN -- when defined, any access whose
// byte address is >= MEM_BYTES is reported as an error and never touches
// memory. When undefined, the address is passed to memory unchecked.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_read_addr,
  output logic [31:0] mem_write_addr,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Access size encodings on req_size (2'b11 is reserved and always faults).
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Memory size must be a whole number of words.
  if ((MEM_BYTES % 4) != 0) begin : g_memBytesNotWordMultiple
    $error("load_store_unit: MEM_BYTES must be a multiple of 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  // Latched request fields needed after the accept edge.
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  // Registered outputs.
  logic        r_respValid;
  logic        r_respError;
  logic [31:0] r_respRdata;
  logic [31:0] r_memAddr;
  logic        r_memWe;
  logic [31:0] r_memWdata;

  // Decode of the incoming request.
  logic        w_misaligned;
  logic        w_outOfRange;
  logic        w_reqError;

  // Load formatting and store merge datapaths.
  logic [7:0]  w_loadLow;
  logic [7:0]  w_loadHigh;
  logic [31:0] w_loadData;
  logic [31:0] w_mergeData;

  // Reverse byte order between memory lanes and core-visible little-endian.
  function automatic logic [31:0] byteSwap(input logic [31:0] word);
    byteSwap = {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

  // Extract the byte that lives at word offset k (offset 0 is bits [31:24]).
  function automatic logic [7:0] laneByte(input logic [31:0] word,
                                          input logic [1:0]  k);
    case (k)
      2'd0:    laneByte = word[31:24];
      2'd1:    laneByte = word[23:16];
      2'd2:    laneByte = word[15:8];
      default: laneByte = word[7:0];
    endcase
  endfunction

  // Replace the byte at word offset k, leaving the other three intact.
  function automatic logic [31:0] setLane(input logic [31:0] word,
                                          input logic [1:0]  k,
                                          input logic [7:0]  value);
    logic [31:0] result;
    result = word;
    case (k)
      2'd0:    result[31:24] = value;
      2'd1:    result[23:16] = value;
      2'd2:    result[15:8]  = value;
      default: result[7:0]   = value;
    endcase
    setLane = result;
  endfunction

  assign w_misaligned = (req_size == SZ_RSVD) ||
                        ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [31:0] LP_MEM_LIMIT = 32'(MEM_BYTES);
  assign w_outOfRange = (req_addr >= LP_MEM_LIMIT);
`else
  assign w_outOfRange = 1'b0;
`endif

  assign w_reqError = w_misaligned || w_outOfRange;

  // Next-state selection: route each accepted access down its own path.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_reqError) begin
            w_stateNext = DONE;
          end else if (!req_write) begin
            w_stateNext = LOAD;
          end else if (req_size == SZ_WORD) begin
            w_stateNext = WRITE;
          end else begin
            w_stateNext = RMW_RD;
          end
        end
      end
      LOAD:    w_stateNext = DONE;
      RMW_RD:  w_stateNext = WRITE;
      WRITE:   w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // State register; reset abandons whatever access is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Format the memory word as a load result, extending sub-word values.
  always_comb begin
    w_loadLow  = laneByte(mem_read_data, r_lane);
    w_loadHigh = laneByte(mem_read_data, r_lane + 2'd1);
    w_loadData = '0;
    case (r_size)
      SZ_BYTE: w_loadData = {{24{~r_unsigned & w_loadLow[7]}}, w_loadLow};
      SZ_HALF: w_loadData = {{16{~r_unsigned & w_loadHigh[7]}}, w_loadHigh, w_loadLow};
      default: w_loadData = byteSwap(mem_read_data);
    endcase
  end

  // Merge sub-word store data into the word read back from memory.
  always_comb begin
    w_mergeData = setLane(mem_read_data, r_lane, r_wdata[7:0]);
    if (r_size == SZ_HALF) begin
      w_mergeData = setLane(w_mergeData, r_lane + 2'd1, r_wdata[15:8]);
    end
  end

  // Request latching and all registered outputs, advanced per state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_respValid <= 1'b0;
      r_respError <= 1'b0;
      r_respRdata <= '0;
      r_memAddr   <= '0;
      r_memWe     <= 1'b0;
      r_memWdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_respValid <= 1'b0;
          r_respError <= 1'b0;
          r_respRdata <= '0;
          r_memWe     <= 1'b0;
          if (req_valid) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            r_memAddr  <= {req_addr[31:2], 2'b00};
            if (w_reqError) begin
              r_respValid <= 1'b1;
              r_respError <= 1'b1;
            end else if (req_write && (req_size == SZ_WORD)) begin
              r_memWe    <= 1'b1;
              r_memWdata <= byteSwap(req_wdata);
            end
          end
        end
        LOAD: begin
          r_respValid <= 1'b1;
          r_respRdata <= w_loadData;
        end
        RMW_RD: begin
          r_memWe    <= 1'b1;
          r_memWdata <= w_mergeData;
        end
        WRITE: begin
          r_memWe     <= 1'b0;
          r_respValid <= 1'b1;
          r_respRdata <= '0;
        end
        DONE: begin
          r_respValid <= 1'b0;
          r_respError <= 1'b0;
          r_respRdata <= '0;
        end
        default: begin
          r_respValid <= 1'b0;
          r_respError <= 1'b0;
          r_memWe     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready        = (r_state == IDLE);
  assign resp_valid       = r_respValid;
  assign resp_error       = r_respError;
  assign resp_rdata       = r_respRdata;
  assign mem_read_addr    = r_memAddr;
  assign mem_write_addr   = r_memAddr;
  assign mem_write_enable = r_memWe;
  assign mem_write_data   = r_memWdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning byte size of the attached memory; must be a multiple of 4.
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, meaning the core presents an access.
REQ-005 SHALL have port req_ready, output, 1, meaning the unit accepts an access this cycle.
REQ-006 SHALL have port req_write, input, 1, meaning 1=store, 0=load.
REQ-007 SHALL have port req_size, input, 2, meaning 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1, meaning zero-extend loads (1) or sign-extend (0).
REQ-009 SHALL have ports req_addr and req_wdata, input, 32 each, meaning byte address and store data (data in low bits).
REQ-010 SHALL have ports resp_valid (1), resp_error (1) and resp_rdata (32), output, meaning completion pulse, fault flag and load result.
REQ-011 SHALL have ports mem_read_addr and mem_write_addr, output, 32 each, meaning memory word addresses, always equal.
REQ-012 SHALL have ports mem_write_enable (1) and mem_write_data (32), output, meaning memory write strobe and data.
REQ-013 SHALL have port mem_read_data, input, 32, meaning combinational memory read data; bits [31:24] hold byte at the address and [7:0] byte at address+3.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, DONE; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge in IDLE with req_valid=1; the request fields are latched and mem addresses are set to {req_addr[31:2],2'b00}.
REQ-016 SHALL flag an error for reserved size, a half access with addr[0]=1, or a word access with addr[1:0]!=0; an error goes IDLE->DONE with no memory write.
REQ-017 Load SHALL go IDLE->LOAD->DONE; mem_read_data is sampled at the end of LOAD, and resp_valid rises 2 edges after acceptance.
REQ-018 Load formatting with k=addr[1:0]: byte = rd[31-8k -:8]; half = {rd[23-8k -:8], rd[31-8k -:8]}; word = {rd[7:0],rd[15:8],rd[23:16],rd[31:24]}; sub-word results are extended per req_unsigned.
REQ-019 Word store SHALL go IDLE->WRITE->DONE with mem_write_data = byte-swapped req_wdata.
REQ-020 Sub-word store SHALL go IDLE->RMW_RD->WRITE->DONE; RMW_RD samples mem_read_data and replaces only the addressed byte(s) using the REQ-018 lane mapping; all other bytes are preserved.
REQ-021 mem_write_enable SHALL be registered and high for exactly the one WRITE cycle per store, and never otherwise.
REQ-022 DONE SHALL last one cycle with resp_valid=1 and then return to IDLE; there is no response backpressure.
REQ-023 In DONE, resp_rdata SHALL be 0 for stores and errors.
REQ-024 req_valid outside IDLE SHALL be ignored.
REQ-025 All outputs except req_ready SHALL be registered.

Reset
REQ-026 reset_n low SHALL immediately force IDLE with req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_write_enable=0, mem addresses=0 and mem_write_data=0.
REQ-027 Reset asserted mid-operation SHALL abandon the access; a store aborted before its WRITE edge leaves memory unchanged.

Configuration
REQ-028 With LSU_RANGE_CHECK_EN defined, an access whose address is >= MEM_BYTES SHALL be an error per REQ-016.
REQ-029 Without LSU_RANGE_CHECK_EN, the address SHALL be used unchecked.

Verification
REQ-030 Word store 0x11223344 to 0x100, then word load from 0x100 -> memory bytes 0x100..0x103 = 44 33 22 11; resp_rdata=0x11223344; load resp_valid 2 cycles after accept.
REQ-031 Byte store 0xAB to 0x102 over that word -> memory = 44 33 AB 11; signed byte load of 0x102 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-032 Half store 0x8001 to 0x106, then signed half load -> 0xFFFF8001; bytes 0x104/0x105 unchanged.
REQ-033 Word load at 0x102 or half load at 0x101 -> resp_error=1, resp_rdata=0, and no mem_write_enable pulse.
REQ-034 Assert reset_n low in the RMW_RD cycle of a byte store -> all outputs go to reset values immediately, no write occurs, and req_ready=1 after release.
REQ-035 With LSU_RANGE_CHECK_EN defined, a load from 0x1000 -> resp_error=1; without it, the access proceeds as normal.
